// File: rtl/vector_denormalizer_if.sv
// ---------------------------------------------------------------------------
// vector_denormalizer_if
// Request/response bundle for vector_denormalizer.
//   start, nx, ny, nz, inv_mag : request side (driven by the master)
//   vx, vy, vz, mag            : reconstructed vector and magnitude, Q16.16
//   valid_out                  : one-cycle pulse when results update
//   busy                       : transaction in flight
//   err, sat                   : inv_mag <= 0 / saturation of any output
// ---------------------------------------------------------------------------
interface vector_denormalizer_if #(
    parameter int DW = 32
);
    logic                 start;
    logic signed [DW-1:0] nx;
    logic signed [DW-1:0] ny;
    logic signed [DW-1:0] nz;
    logic signed [DW-1:0] inv_mag;
    logic signed [DW-1:0] vx;
    logic signed [DW-1:0] vy;
    logic signed [DW-1:0] vz;
    logic        [DW-1:0] mag;
    logic                 valid_out;
    logic                 busy;
    logic                 err;
    logic                 sat;

    modport master (
        output start, nx, ny, nz, inv_mag,
        input  vx, vy, vz, mag, valid_out, busy, err, sat
    );

    modport slave (
        input  start, nx, ny, nz, inv_mag,
        output vx, vy, vz, mag, valid_out, busy, err, sat
    );
endinterface

// File: rtl/vector_denormalizer.sv
// ---------------------------------------------------------------------------
// vector_denormalizer
// Rebuilds V = n * |V| from a unit vector n and its inverse magnitude, with
// |V| = 2^(2*FB) / inv_mag computed by a restoring divider (DW+1 iterations,
// one quotient bit per clock) followed by a single scaling cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : vector_denormalizer_if.slave (request inputs, results and status)
// Fixed latency: valid_out rises after the 34th edge following acceptance.
// Optional: define DENORM_ROUND_EN to round component products half up
// before the fractional shift (default build truncates).
// ---------------------------------------------------------------------------
module vector_denormalizer #(
    parameter int DW = 32,
    parameter int FB = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_denormalizer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        SCALE
    } state_t;

    localparam int CW = $clog2(DW + 1);

    localparam logic [2*DW-1:0] DIVIDEND = {{(2*DW-1){1'b0}}, 1'b1} << (2 * FB);

    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    // Signed limits widened to product width for the clamp compare
    localparam logic signed [2*DW-1:0] WMAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW-1:0] WMIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

`ifdef DENORM_ROUND_EN
    localparam logic signed [2*DW-1:0] RND = {{(2*DW-1){1'b0}}, 1'b1} << (FB - 1);
`endif

    state_t state, state_next;

    logic signed [DW-1:0] n_x, n_y, n_z;
    logic        [DW-1:0] divisor;
    logic                 err_q;
    logic        [DW-1:0] rem;
    logic        [DW:0]   quo;
    logic        [CW-1:0] cnt;

    logic                 accept;
    logic                 do_scale;

    logic        [DW:0]   trial;
    logic        [DW-1:0] trial_sub;
    logic                 q_bit;
    logic        [DW-1:0] rem_next;

    logic        [DW-1:0] mag_val;
    logic                 mag_clip;
    logic        [DW:0]   cx, cy, cz;

    // Returns {clip, value}: (n * m) >>> FB clamped to the signed DW range
    function automatic logic [DW:0] scale_comp(
        input logic signed [DW-1:0] n,
        input logic        [DW-1:0] m
    );
        logic signed [2*DW-1:0] a;
        logic signed [2*DW-1:0] b;
        logic signed [2*DW-1:0] prod;
        logic signed [2*DW-1:0] shifted;
        a    = {{DW{n[DW-1]}}, n};
        b    = {{DW{1'b0}}, m};
        prod = a * b;
`ifdef DENORM_ROUND_EN
        prod = prod + RND;
`endif
        shifted = prod >>> FB;
        if (shifted > WMAX) begin
            return {1'b1, SMAX};
        end else if (shifted < WMIN) begin
            return {1'b1, SMIN};
        end else begin
            return {1'b0, shifted[DW-1:0]};
        end
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_scale   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = DIV;
                end
            end
            DIV: begin
                if (cnt == '0) begin
                    state_next = SCALE;
                end
            end
            SCALE: begin
                do_scale   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // ---------------- divider step ----------------
    // Remainder always stays below the divisor, so the subtract fits DW bits.
    always_comb begin
        trial     = {rem, DIVIDEND[cnt]};
        trial_sub = trial[DW-1:0] - divisor;
        q_bit     = (trial >= {1'b0, divisor});
        rem_next  = q_bit ? trial_sub : trial[DW-1:0];
    end

    // ---------------- scaling ----------------
    always_comb begin
        mag_clip = (quo > {1'b0, SMAX});
        mag_val  = mag_clip ? SMAX : quo[DW-1:0];
        cx       = scale_comp(n_x, mag_val);
        cy       = scale_comp(n_y, mag_val);
        cz       = scale_comp(n_z, mag_val);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_x           <= '0;
            n_y           <= '0;
            n_z           <= '0;
            divisor       <= '0;
            err_q         <= 1'b0;
            rem           <= '0;
            quo           <= '0;
            cnt           <= '0;
            bus.vx        <= '0;
            bus.vy        <= '0;
            bus.vz        <= '0;
            bus.mag       <= '0;
            bus.valid_out <= 1'b0;
            bus.err       <= 1'b0;
            bus.sat       <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;

            if (accept) begin
                n_x     <= bus.nx;
                n_y     <= bus.ny;
                n_z     <= bus.nz;
                rem     <= '0;
                quo     <= '0;
                cnt     <= CW'(DW);
                bus.err <= 1'b0;
                bus.sat <= 1'b0;
                // Non-positive divisor: run the divider on 1 to keep latency fixed
                if (bus.inv_mag[DW-1] || (bus.inv_mag == '0)) begin
                    err_q   <= 1'b1;
                    divisor <= {{(DW-1){1'b0}}, 1'b1};
                end else begin
                    err_q   <= 1'b0;
                    divisor <= bus.inv_mag;
                end
            end

            if (state == DIV) begin
                rem <= rem_next;
                quo <= {quo[DW-1:0], q_bit};
                cnt <= cnt - 1'b1;
            end

            if (do_scale) begin
                bus.valid_out <= 1'b1;
                if (err_q) begin
                    bus.vx  <= '0;
                    bus.vy  <= '0;
                    bus.vz  <= '0;
                    bus.mag <= '0;
                    bus.err <= 1'b1;
                    bus.sat <= 1'b0;
                end else begin
                    bus.vx  <= cx[DW-1:0];
                    bus.vy  <= cy[DW-1:0];
                    bus.vz  <= cz[DW-1:0];
                    bus.mag <= mag_val;
                    bus.sat <= mag_clip | cx[DW] | cy[DW] | cz[DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_denormalizer.sv
module tb_vector_denormalizer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vector_denormalizer_if #(.DW(32)) bus ();

    vector_denormalizer #(.DW(32), .FB(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] vx;
        logic [31:0] vy;
        logic [31:0] vz;
        logic [31:0] mag;
        logic        err;
        logic        sat;
    } res_t;

    typedef struct {
        logic [31:0] nx;
        logic [31:0] ny;
        logic [31:0] nz;
        logic [31:0] inv;
        res_t        exp;
    } vec_t;

    int tests = 0;
    int fails = 0;

    localparam int LAT = 34;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [32:0] model_comp(input logic [31:0] n, input longint m);
        longint p;
        p = longint'($signed(n)) * m;
`ifdef DENORM_ROUND_EN
        p = p + 32768;
`endif
        p = p >>> 16;
        if (p > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        if (p < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, p[31:0]};
    endfunction

    function automatic res_t model(input logic [31:0] nx, input logic [31:0] ny,
                                   input logic [31:0] nz, input logic [31:0] inv);
        res_t        r;
        longint      iv;
        longint      q;
        logic [32:0] c;
        r  = '{vx: '0, vy: '0, vz: '0, mag: '0, err: 1'b0, sat: 1'b0};
        iv = longint'($signed(inv));
        if (iv <= 0) begin
            r.err = 1'b1;
            return r;
        end
        q = (longint'(1) << 32) / iv;
        if (q > 2147483647) begin
            q     = 2147483647;
            r.sat = 1'b1;
        end
        r.mag = q[31:0];
        c = model_comp(nx, q); r.vx = c[31:0]; r.sat = r.sat | c[32];
        c = model_comp(ny, q); r.vy = c[31:0]; r.sat = r.sat | c[32];
        c = model_comp(nz, q); r.vz = c[31:0]; r.sat = r.sat | c[32];
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] nx, ny, nz, inv,
                                input logic [31:0] vx, vy, vz, mag,
                                input logic err, input logic sat);
        vec_t v;
        v.nx = nx; v.ny = ny; v.nz = nz; v.inv = inv;
        v.exp.vx = vx; v.exp.vy = vy; v.exp.vz = vz; v.exp.mag = mag;
        v.exp.err = err; v.exp.sat = sat;
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic snap(output res_t r);
        r.vx  = bus.vx;
        r.vy  = bus.vy;
        r.vz  = bus.vz;
        r.mag = bus.mag;
        r.err = bus.err;
        r.sat = bus.sat;
    endtask

    task automatic check_res(input string tag, input res_t got, input res_t exp);
        check({tag, ".vx"},  got.vx,  exp.vx);
        check({tag, ".vy"},  got.vy,  exp.vy);
        check({tag, ".vz"},  got.vz,  exp.vz);
        check({tag, ".mag"}, got.mag, exp.mag);
        check({tag, ".err"}, got.err, exp.err);
        check({tag, ".sat"}, got.sat, exp.sat);
    endtask

    task automatic set_in(input logic [31:0] nx, ny, nz, inv);
        bus.nx      = nx;
        bus.ny      = ny;
        bus.nz      = nz;
        bus.inv_mag = inv;
    endtask

    task automatic scramble_in();
        set_in($urandom, $urandom, $urandom, $urandom);
    endtask

    // Waits up to 100 edges for valid_out; lat = edge count, or -1 on timeout
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (bus.valid_out) begin
                lat = k;
                break;
            end
        end
    endtask

    // One transaction from IDLE; inputs are scrambled right after acceptance
    task automatic do_txn(input string tag, input logic [31:0] nx, ny, nz, inv,
                          output res_t got);
        int lat;
        @(posedge clk); #1;
        set_in(nx, ny, nz, inv);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble_in();
        check({tag, ".busy_after_accept"}, bus.busy, 1'b1);
        wait_valid(lat);
        check({tag, ".latency"}, lat, LAT);
        check({tag, ".busy_at_valid"}, bus.busy, 1'b0);
        snap(got);
        @(posedge clk); #1;
        check({tag, ".valid_single_pulse"}, bus.valid_out, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[8];

    initial begin
        res_t got;
        res_t ea;
        res_t eb;
        int   lat;
        int   pulses;
        int   first;
        logic [31:0] a_nx, a_ny, a_nz, a_inv;

`ifdef DENORM_ROUND_EN
        logic [31:0] round_vx = 32'h1;
`else
        logic [31:0] round_vx = 32'h0;
`endif

        tbl[0] = mk(32'h0000_8000, 32'hFFFF_8000, 32'h0, 32'h0001_0000,
                    32'h0000_8000, 32'hFFFF_8000, 32'h0, 32'h0001_0000, 1'b0, 1'b0);
        tbl[1] = mk(32'h0000_999A, 32'h0000_CCCD, 32'h0, 32'h0000_4000,
                    32'h0002_6668, 32'h0003_3334, 32'h0, 32'h0004_0000, 1'b0, 1'b0);
        tbl[2] = mk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tbl[3] = mk(32'h0001_0000, 32'h0, 32'hFFFF_0000, 32'h0002_0000,
                    32'h0000_8000, 32'h0, 32'hFFFF_8000, 32'h0000_8000, 1'b0, 1'b0);
        tbl[4] = mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000,
                    32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tbl[5] = mk(32'h0001_0000, 32'h0, 32'h0, 32'h0000_0001,
                    32'h7FFF_FFFF, 32'h0, 32'h0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        tbl[6] = mk(32'h0000_0003, 32'h0, 32'h0, 32'h0003_0000,
                    round_vx, 32'h0, 32'h0, 32'h0000_5555, 1'b0, 1'b0);
        tbl[7] = mk(32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'h0000_8000,
                    32'h7FFF_FFFF, 32'h8000_0000, 32'h0002_0000, 32'h0002_0000, 1'b0, 1'b1);

        // Reset state
        rst       = 1'b1;
        bus.start = 1'b0;
        set_in('0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        snap(got);
        check_res("reset", got, '{vx: '0, vy: '0, vz: '0, mag: '0, err: 1'b0, sat: 1'b0});
        check("reset.valid", bus.valid_out, 1'b0);
        check("reset.busy", bus.busy, 1'b0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].nx, tbl[i].ny, tbl[i].nz, tbl[i].inv, got);
            check_res($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // Randomized against the model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] rnx, rny, rnz, rinv;
            rnx = 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000;
            rny = 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000;
            rnz = (i % 4 == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000;
            case ($urandom_range(0, 3))
                0:       rinv = 32'($urandom_range(1, 32'h0000_FFFF));
                1:       rinv = {1'b0, 31'($urandom)};
                2:       rinv = 32'h0000_8000 + 32'($urandom_range(0, 32'h0002_0000));
                default: rinv = $urandom;
            endcase
            do_txn($sformatf("rnd%0d", i), rnx, rny, rnz, rinv, got);
            check_res($sformatf("rnd%0d", i), got, model(rnx, rny, rnz, rinv));
        end

        // start during busy is ignored; inputs changing after acceptance
        a_nx = 32'h0000_999A; a_ny = 32'hFFFF_3333; a_nz = 32'h0000_4000; a_inv = 32'h0000_C000;
        ea = model(a_nx, a_ny, a_nz, a_inv);
        @(posedge clk); #1;
        set_in(a_nx, a_ny, a_nz, a_inv);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pulses = 0;
        first  = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (bus.valid_out) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    snap(got);
                end
            end
            bus.start = (k == 4 || k == 19);
            if (bus.start) scramble_in();
        end
        bus.start = 1'b0;
        check("ignore.pulses", pulses, 1);
        check("ignore.latency", first, LAT);
        check_res("ignore", got, ea);

        // Reset mid-DIV aborts the transaction
        @(posedge clk); #1;
        set_in(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        snap(got);
        check_res("midrst", got, '{vx: '0, vy: '0, vz: '0, mag: '0, err: 1'b0, sat: 1'b0});
        check("midrst.busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus.valid_out) pulses++;
        end
        check("midrst.no_valid", pulses, 0);
        do_txn("after_rst", 32'h0000_4000, 32'hFFFF_C000, 32'h0001_0000, 32'h0000_2000, got);
        check_res("after_rst", got, model(32'h0000_4000, 32'hFFFF_C000, 32'h0001_0000, 32'h0000_2000));

        // start held through valid_out: second transaction accepted at once
        ea = model(32'h0000_1234, 32'h0000_5678, 32'hFFFF_0000, 32'h0000_3000);
        eb = model(32'hFFFF_8000, 32'h0000_0100, 32'h0000_7FFF, 32'h0000_0000);
        @(posedge clk); #1;
        set_in(32'h0000_1234, 32'h0000_5678, 32'hFFFF_0000, 32'h0000_3000);
        bus.start = 1'b1;
        @(posedge clk); #1;
        wait_valid(lat);
        check("b2b.first_latency", lat, LAT);
        snap(got);
        check_res("b2b.first", got, ea);
        set_in(32'hFFFF_8000, 32'h0000_0100, 32'h0000_7FFF, 32'h0000_0000);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b.busy_second", bus.busy, 1'b1);
        check("b2b.err_cleared", bus.err, 1'b0);
        scramble_in();
        wait_valid(lat);
        check("b2b.second_latency", lat, LAT);
        snap(got);
        check_res("b2b.second", got, eb);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
